// File: rtl/datapath_seq.sv
// Sequenced register-file datapath: one register-to-register operation per accepted
// command, with a barrel-shifted B operand, status flags and a selectable writeback source.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RD_A  | A <= R[rn]
// RD_B  | B <= R[rm]
// EXEC  | C <= ALU result, flags updated when setflags
// WB    | done pulse, R[rd] written at the end of the cycle when wb
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 9,
  localparam int AW  = $clog2(NREGS),
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rn,
  input  logic [AW-1:0]    cmd_rm,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [1:0]       cmd_shift,
  input  logic [SHW-1:0]   cmd_shamt,
  input  logic             cmd_asel,
  input  logic             cmd_bsel,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [1:0]       cmd_vsel,
  input  logic             cmd_wb,
  input  logic             cmd_setflags,
  input  logic [PC_W-1:0]  pc,
  input  logic [WIDTH-1:0] mdata,
  output logic             done,
  output logic [WIDTH-1:0] datapath_out,
  output logic             Z_out,
  output logic             N_out,
  output logic             V_out,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   accept, ld_a, ld_b, ld_c, wr_en;

  logic [1:0]       q_op, q_shift, q_vsel;
  logic [AW-1:0]    q_rn, q_rm, q_rd;
  logic [SHW-1:0]   q_shamt;
  logic             q_asel, q_bsel, q_wb, q_sf;
  logic [WIDTH-1:0] q_imm;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic             z_reg, n_reg, v_reg;

  logic [WIDTH-1:0] b_sh, ain, bin, alu_res, wdata;
  logic             alu_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_c      = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_RD_A;
      end
      S_RD_A: begin
        ld_a      = 1'b1;
        state_nxt = S_RD_B;
      end
      S_RD_B: begin
        ld_b      = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        ld_c      = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        done      = 1'b1;
        wr_en     = q_wb;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_op    <= '0;
      q_rn    <= '0;
      q_rm    <= '0;
      q_rd    <= '0;
      q_shift <= '0;
      q_shamt <= '0;
      q_asel  <= 1'b0;
      q_bsel  <= 1'b0;
      q_imm   <= '0;
      q_vsel  <= '0;
      q_wb    <= 1'b0;
      q_sf    <= 1'b0;
    end else if (accept) begin
      q_op    <= cmd_op;
      q_rn    <= cmd_rn;
      q_rm    <= cmd_rm;
      q_rd    <= cmd_rd;
      q_shift <= cmd_shift;
      q_shamt <= cmd_shamt;
      q_asel  <= cmd_asel;
      q_bsel  <= cmd_bsel;
      q_imm   <= cmd_imm;
      q_vsel  <= cmd_vsel;
      q_wb    <= cmd_wb;
      q_sf    <= cmd_setflags;
    end
  end

  always_comb begin
    case (q_shift)
      2'b01:   b_sh = b_reg << q_shamt;
      2'b10:   b_sh = b_reg >> q_shamt;
      2'b11:   b_sh = $unsigned($signed(b_reg) >>> q_shamt);
      default: b_sh = b_reg;
    endcase
  end

  assign ain = q_asel ? '0 : a_reg;
  assign bin = q_bsel ? q_imm : b_sh;

  // overflow: operands of matching effective sign produce a result of the other sign
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (q_op)
      2'b00: begin
        alu_res = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b01: begin
        alu_res = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  always_comb begin
    case (q_vsel)
      2'b00:   wdata = c_reg;
      2'b01:   wdata = WIDTH'(pc);
      2'b10:   wdata = q_imm;
      default: wdata = mdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      z_reg <= 1'b0;
      n_reg <= 1'b0;
      v_reg <= 1'b0;
    end else begin
      if (ld_a) a_reg <= regs[q_rn];
      if (ld_b) b_reg <= regs[q_rm];
      if (ld_c) begin
        c_reg <= alu_res;
        if (q_sf) begin
          z_reg <= (alu_res == '0);
          n_reg <= alu_res[WIDTH-1];
          v_reg <= alu_v;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[q_rd] <= wdata;
    end
  end

  assign datapath_out = c_reg;
  assign Z_out        = z_reg;
  assign N_out        = n_reg;
  assign V_out        = v_reg;
  assign dbg_data     = regs[dbg_addr];

endmodule
